// File: rtl/iter_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO pair for the EX stage.
// Multiply: radix-2^MUL_STEP shift-add on magnitudes; divide: restoring, DIV_STEP bits/cycle.
// Optional build macro: MULDIV_ACCUM_EN makes ops 4-7 accumulate into {hi,lo}
// (MADD/MADDU add, MSUB/MSUBU subtract); without it they act as MULT/MULTU.
module iter_muldiv_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 2,
  parameter int unsigned DIV_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hold,
  output logic             ready_o,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  input  logic             hi_we,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] lo_wdata
);

  localparam int unsigned DW      = 2 * WIDTH;
  localparam int unsigned MUL_CNT = WIDTH / MUL_STEP;
  localparam int unsigned DIV_CNT = WIDTH / DIV_STEP;
  localparam int unsigned CNT_W   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // a_q: multiplier (shifts right) or dividend/quotient (shifts left)
  logic [WIDTH-1:0]   a_q, a_d;
  // b_q: multiplicand (shifts left) or divisor in the low half
  logic [DW-1:0]      b_q, b_d;
  // acc_q: product accumulator or partial remainder in the low half
  logic [DW-1:0]      acc_q, acc_d;
  logic               neg_q, neg_d;    // negate product / quotient
  logic               rneg_q, rneg_d;  // negate remainder (dividend sign)
  logic               dz_q, dz_d;      // divisor was zero
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
`ifdef MULDIV_ACCUM_EN
  logic               accum_q, accum_d;
  logic               sub_q, sub_d;
`endif

  logic               ready_c, accept_c, is_div_c, sa_c, sb_c;
  logic [WIDTH-1:0]   mag_a_c, mag_b_c;
  logic [DW-1:0]      mul_sum_c, prod_c, mul_res_c;
  logic [WIDTH-1:0]   div_quo_c, div_rem_c, rem_mag_c, quo_fin_c, rem_fin_c;
  logic [WIDTH:0]     rem_t;
  logic [WIDTH-1:0]   quo_t;

  assign ready_c  = (state_q == S_IDLE) || ((state_q == S_DONE) && !hold);
  assign accept_c = start && ready_c && !flush;
  assign ready_o  = ready_c;
  assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
  assign done     = (state_q == S_DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Operand sign decode and magnitude correction at accept
  always_comb begin
    is_div_c = (op[2:1] == 2'b01);
    sa_c     = !op[0] && src_a[WIDTH-1];
    sb_c     = !op[0] && src_b[WIDTH-1];
    mag_a_c  = sa_c ? -src_a : src_a;
    mag_b_c  = sb_c ? -src_b : src_b;
  end

  // One shift-add multiply step: add multiplicand for each set multiplier bit
  always_comb begin
    mul_sum_c = acc_q;
    for (int unsigned j = 0; j < MUL_STEP; j++) begin
      if (a_q[j]) mul_sum_c = mul_sum_c + (b_q << j);
    end
  end

  // One restoring-division step producing DIV_STEP quotient bits
  always_comb begin
    rem_t = {1'b0, acc_q[WIDTH-1:0]};
    quo_t = a_q;
    for (int unsigned j = 0; j < DIV_STEP; j++) begin
      rem_t = {rem_t[WIDTH-1:0], quo_t[WIDTH-1]};
      quo_t = {quo_t[WIDTH-2:0], 1'b0};
      if (rem_t >= {1'b0, b_q[WIDTH-1:0]}) begin
        rem_t    = rem_t - {1'b0, b_q[WIDTH-1:0]};
        quo_t[0] = 1'b1;
      end
    end
    div_rem_c = rem_t[WIDTH-1:0];
    div_quo_c = quo_t;
  end

  // Final sign fix-up and optional accumulation of the finished result
  always_comb begin
    prod_c    = neg_q ? -acc_q : acc_q;
    mul_res_c = prod_c;
`ifdef MULDIV_ACCUM_EN
    if (accum_q) begin
      mul_res_c = sub_q ? ({hi_q, lo_q} - prod_c) : ({hi_q, lo_q} + prod_c);
    end
`endif
    rem_mag_c = acc_q[WIDTH-1:0];
    if (dz_q) begin
      quo_fin_c = '1;
      rem_fin_c = rneg_q ? -a_q : a_q;
    end else begin
      quo_fin_c = neg_q ? -a_q : a_q;
      rem_fin_c = rneg_q ? -rem_mag_c : rem_mag_c;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_ACCUM_EN
    accum_d = accum_q;
    sub_d   = sub_q;
`endif

    if (ready_c && hi_we) hi_d = hi_wdata;
    if (ready_c && lo_we) lo_d = lo_wdata;

    unique case (state_q)
      S_IDLE: ;
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
          hi_d    = mul_res_c[DW-1:WIDTH];
          lo_d    = mul_res_c[WIDTH-1:0];
        end else begin
          acc_d = mul_sum_c;
          b_d   = b_q << MUL_STEP;
          a_d   = a_q >> MUL_STEP;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
          hi_d    = rem_fin_c;
          lo_d    = quo_fin_c;
        end else begin
          if (!dz_q) begin
            acc_d = {{WIDTH{1'b0}}, div_rem_c};
            a_d   = div_quo_c;
          end
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (flush || !hold) state_d = S_IDLE;
      end
    endcase

    // Launch: only reachable from IDLE or released DONE, never with flush
    if (accept_c) begin
      neg_d  = sa_c ^ sb_c;
      rneg_d = sa_c;
      acc_d  = '0;
`ifdef MULDIV_ACCUM_EN
      accum_d = op[2];
      sub_d   = op[1];
`endif
      if (is_div_c) begin
        state_d = S_DIV;
        dz_d    = (src_b == '0);
        a_d     = mag_a_c;
        b_d     = {{WIDTH{1'b0}}, mag_b_c};
        cnt_d   = (src_b == '0) ? CNT_W'(1) : CNT_W'(DIV_CNT);
      end else begin
        state_d = S_MUL;
        dz_d    = 1'b0;
        a_d     = mag_b_c;
        b_d     = {{WIDTH{1'b0}}, mag_a_c};
        cnt_d   = CNT_W'(MUL_CNT);
      end
    end
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_ACCUM_EN
      accum_q <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULDIV_ACCUM_EN
      accum_q <= accum_d;
      sub_q   <= sub_d;
`endif
    end
  end

endmodule
